branch_resolve_unit: RTL and testbench

//   Resolution end of the 2-bit branch predictor. Serves predictions from a table of
//   2-bit saturating counters and queues each issued prediction in order. As actual

---
 rtl/bp_pkg.sv | 28 ++
 rtl/bp_fifo.sv | 63 ++++++
 rtl/branch_resolve_unit.sv | 93 +++++++++
 tb/tb_branch_resolve_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg : shared counter encodings and update rule for the branch predictor
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bp_pkg;

   localparam logic [1:0] CNT_SNT = 2'b00;
   localparam logic [1:0] CNT_WNT = 2'b01;
   localparam logic [1:0] CNT_WT  = 2'b10;
   localparam logic [1:0] CNT_ST  = 2'b11;

   // Next state of a 2-bit saturating counter given the actual outcome.
   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
      logic [1:0] nxt;
      case (cnt)
         CNT_SNT: nxt = taken ? CNT_WNT : CNT_SNT;
         CNT_WNT: nxt = taken ? CNT_WT  : CNT_SNT;
         CNT_WT:  nxt = taken ? CNT_ST  : CNT_WNT;
         default: nxt = taken ? CNT_ST  : CNT_WT;
      endcase
      return nxt;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bp_fifo.sv
// ---------------------------------------------------------------------------
// bp_fifo : synchronous FIFO with occupancy count and synchronous clear
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push & (count != OCC_W'(DEPTH)) & ~clear;
   assign pop_ok  = pop & (count != '0);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok && reset) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + OCC_W'(1);
            2'b01:   count <= count - OCC_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit : 2-bit counter predictor with in-order resolve queue
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module branch_resolve_unit
   import bp_pkg::*;
#(
   parameter int IDX_W  = 4,
   parameter int QDEPTH = 4,
   parameter int CNT_W  = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      pred_valid,
   output logic                      pred_ready,
   input  logic [IDX_W-1:0]          pred_idx,
   output logic                      pred_taken,
   input  logic                      res_valid,
   output logic                      res_ready,
   input  logic                      res_taken,
   input  logic                      flush,
   output logic                      mispredict,
   output logic [IDX_W-1:0]          mis_idx,
   output logic [CNT_W-1:0]          mismatch_count,
   output logic [$clog2(QDEPTH):0]   inflight
);

   localparam int OCC_W   = $clog2(QDEPTH) + 1;
   localparam int ENTRIES = 2 ** IDX_W;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             pred;
   } entry_t;

   logic [ENTRIES-1:0][1:0] cnt_tbl;
   entry_t                  push_entry;
   entry_t                  head;
   logic                    push_en;
   logic                    pop_en;
   logic                    miss;

   assign pred_ready = (inflight != OCC_W'(QDEPTH));
   assign res_ready  = (inflight != '0);
   assign pred_taken = cnt_tbl[pred_idx][1];

   // Flush discards a same-cycle push; a same-cycle resolve still completes.
   assign push_en    = pred_valid & pred_ready & ~flush;
   assign pop_en     = res_valid & res_ready;
   assign push_entry = '{idx: pred_idx, pred: pred_taken};
   assign miss       = pop_en & (res_taken != head.pred);

   bp_fifo #(
      .DEPTH (QDEPTH),
      .WIDTH ($bits(entry_t))
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (flush),
      .push  (push_en),
      .din   (push_entry),
      .pop   (pop_en),
      .dout  (head),
      .count (inflight)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_tbl <= {ENTRIES{CNT_SNT}};
      end else if (pop_en) begin
         cnt_tbl[head.idx] <= sat_update(cnt_tbl[head.idx], res_taken);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         mispredict     <= 1'b0;
         mis_idx        <= '0;
         mismatch_count <= '0;
      end else begin
         mispredict <= miss;
         if (miss) begin
            mis_idx <= head.idx;
            if (mismatch_count != '1) mismatch_count <= mismatch_count + CNT_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit : directed + randomised scoreboard bench
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_branch_resolve_unit;

   localparam int IDX_W  = 4;
   localparam int QDEPTH = 4;
   localparam int CNT_W  = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             pred_valid;
   logic             pred_ready;
   logic [IDX_W-1:0] pred_idx;
   logic             pred_taken;
   logic             res_valid;
   logic             res_ready;
   logic             res_taken;
   logic             flush;
   logic             mispredict;
   logic [IDX_W-1:0] mis_idx;
   logic [CNT_W-1:0] mismatch_count;
   logic [2:0]       inflight;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             pred;
   } ent_t;

   ent_t             sb[$];
   logic [1:0]       mtab [16];
   int               exp_count;
   logic [IDX_W-1:0] exp_mis_idx;
   int               total = 0;
   int               bad   = 0;

   branch_resolve_unit #(
      .IDX_W  (IDX_W),
      .QDEPTH (QDEPTH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .pred_valid     (pred_valid),
      .pred_ready     (pred_ready),
      .pred_idx       (pred_idx),
      .pred_taken     (pred_taken),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_taken      (res_taken),
      .flush          (flush),
      .mispredict     (mispredict),
      .mis_idx        (mis_idx),
      .mismatch_count (mismatch_count),
      .inflight       (inflight)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      for (int i = 0; i < 16; i++) mtab[i] = 2'b00;
      exp_count   = 0;
      exp_mis_idx = '0;
   endtask

   // One clock: drive at negedge, check comb outputs, update model, check registered outputs.
   task automatic step(input logic pv, input logic [IDX_W-1:0] pi,
                       input logic rv, input logic rt, input logic fl);
      ent_t e;
      logic exp_mis;
      logic pushed_pred;
      logic pready;
      logic rready;
      exp_mis    = 1'b0;
      pred_valid = pv;
      pred_idx   = pv ? pi : 'x;
      res_valid  = rv;
      res_taken  = rv ? rt : 1'bx;
      flush      = fl;
      #1;
      pready = (sb.size() != QDEPTH);
      rready = (sb.size() != 0);
      check("pred_ready", pred_ready, pready);
      check("res_ready", res_ready, rready);
      check("inflight", inflight, sb.size());
      if (pv) check("pred_taken", pred_taken, mtab[pi][1]);
      pushed_pred = mtab[pi][1];
      if (rv && rready) begin
         e = sb.pop_front();
         if (rt != e.pred) begin
            exp_mis     = 1'b1;
            exp_mis_idx = e.idx;
            exp_count++;
         end
         if (rt) mtab[e.idx] = (mtab[e.idx] == 2'd3) ? 2'd3 : mtab[e.idx] + 2'd1;
         else    mtab[e.idx] = (mtab[e.idx] == 2'd0) ? 2'd0 : mtab[e.idx] - 2'd1;
      end
      if (fl) sb.delete();
      else if (pv && pready) sb.push_back('{idx: pi, pred: pushed_pred});
      @(posedge clk);
      @(negedge clk);
      check("mispredict", mispredict, exp_mis);
      check("mis_idx", mis_idx, exp_mis_idx);
      check("mismatch_count", mismatch_count, exp_count);
      pred_valid = 1'b0;
      res_valid  = 1'b0;
      flush      = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      #1;
      check({tag, "_inflight"}, inflight, 0);
      check({tag, "_mispredict"}, mispredict, 0);
      check({tag, "_mis_idx"}, mis_idx, 0);
      check({tag, "_count"}, mismatch_count, 0);
      check({tag, "_pred_ready"}, pred_ready, 1);
      check({tag, "_res_ready"}, res_ready, 0);
      pred_idx = 4'd3;
      #1;
      check({tag, "_pred_taken"}, pred_taken, 0);
   endtask

   initial begin
      reset      = 1'b0;
      pred_valid = 1'b0;
      pred_idx   = '0;
      res_valid  = 1'b0;
      res_taken  = 1'b0;
      flush      = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      check_reset_state("reset");
      @(negedge clk);

      // 1: learn idx 3 towards taken
      step(1, 4'd3, 0, 0, 0);
      step(1, 4'd3, 0, 0, 0);
      step(0, 0, 1, 1, 0);
      step(0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 0);
      check("t1_count", mismatch_count, 2);
      step(1, 4'd3, 0, 0, 0);
      check("t1_flip", sb[0].pred, 1'b1);
      step(0, 0, 1, 1, 0);

      // 2: saturation on idx 5
      for (int i = 0; i < 5; i++) begin
         step(1, 4'd5, 0, 0, 0);
         step(0, 0, 1, 1, 0);
      end
      check("t2_sat_hi", mtab[5], 2'b11);
      for (int i = 0; i < 5; i++) begin
         step(1, 4'd5, 0, 0, 0);
         step(0, 0, 1, 0, 0);
      end
      step(1, 4'd5, 0, 0, 0);
      step(0, 0, 1, 0, 0);

      // 3: fill, overflow attempt, drain one
      for (int i = 0; i < 4; i++) step(1, 4'(i + 8), 0, 0, 0);
      step(1, 4'd12, 0, 0, 0);
      check("t3_full", inflight, 4);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      check("t3_ready", pred_ready, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);

      // 4: resolve on empty queue
      step(0, 0, 1, 1, 0);
      step(0, 0, 1, 0, 0);
      check("t4_empty", res_ready, 0);

      // 5: simultaneous predict and resolve on idx 2 (table 01)
      step(1, 4'd2, 0, 0, 0);
      step(0, 0, 1, 1, 0);
      step(1, 4'd2, 0, 0, 0);
      step(1, 4'd2, 1, 1, 0);
      check("t5_inflight", inflight, 1);
      step(1, 4'd2, 0, 0, 0);
      step(0, 0, 1, 1, 0);
      step(0, 0, 1, 1, 0);

      // 6: flush with 3 in flight plus mispredicting resolve and dropped push
      step(1, 4'd7, 0, 0, 0);
      step(1, 4'd7, 0, 0, 0);
      step(1, 4'd7, 0, 0, 0);
      step(1, 4'd7, 1, 1, 1);
      check("t6_inflight", inflight, 0);
      step(0, 0, 1, 1, 0);

      // randomised traffic
      for (int i = 0; i < 120; i++) begin
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 15) == 0));
      end

      // reset mid-operation with a mispredicting resolve pending
      step(1, 4'd1, 0, 0, 0);
      step(1, 4'd1, 0, 0, 0);
      reset     = 1'b0;
      res_valid = 1'b1;
      res_taken = ~mtab[1][1];
      @(posedge clk);
      @(negedge clk);
      reset     = 1'b1;
      res_valid = 1'b0;
      model_reset();
      check_reset_state("midreset");
      @(negedge clk);
      step(1, 4'd1, 0, 0, 0);
      step(0, 0, 1, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
